// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel converter with word framing.
// Collects WIDTH bits strobed by en, in MSB-first or LSB-first order chosen
// at the first bit of each word. Completed words go to a registered holding
// register with a valid/ready handshake. A word that completes while the
// holding register is still full is dropped and sets a sticky overrun flag.
// Optional build macro SIPO_PARITY_EN: each frame carries one extra even-parity
// bit after the data bits, and the par_err output is added.
module sipo_deserializer #(
  parameter int unsigned WIDTH = 16,
`ifdef SIPO_PARITY_EN
  localparam int unsigned CW = $clog2(WIDTH + 1)
`else
  localparam int unsigned CW = $clog2(WIDTH)
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             d,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_cnt,
`ifdef SIPO_PARITY_EN
  output logic             par_err,
`endif
  output logic             overrun
);

  // Counter value on which a frame completes: the parity bit, when present,
  // comes after the last data bit.
`ifdef SIPO_PARITY_EN
  localparam int unsigned LAST = WIDTH;
`else
  localparam int unsigned LAST = WIDTH - 1;
`endif

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shift;
  logic [WIDTH-1:0] cand;
  logic             dir_l;
  logic             dir_eff;
  logic             take;
  logic             first_bit;
  logic             last_bit;
  logic             data_bit;
  logic             complete;
  logic             load;
  logic             drop;

  // Decode of the current edge: shift value, completion and handshake outcome.
  always_comb begin
    take      = en & ~clr;
    first_bit = (bit_cnt == '0);
    last_bit  = (bit_cnt == CW'(LAST));
    // The first bit of a word uses the live dir; later bits use the latch.
    dir_eff   = first_bit ? dir : dir_l;
    sh_shift  = dir_eff ? {d, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], d};
`ifdef SIPO_PARITY_EN
    // The parity bit is not part of the word, so the candidate is sh as-is.
    data_bit  = ~last_bit;
    cand      = sh;
`else
    // The completing bit is itself a data bit and belongs in the candidate.
    data_bit  = 1'b1;
    cand      = sh_shift;
`endif
    complete  = take & last_bit;
    load      = complete & (~out_valid | out_ready);
    drop      = complete & out_valid & ~out_ready;
  end

  // Accumulation state: shift register, bit counter, per-word direction latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh      <= '0;
      bit_cnt <= '0;
      dir_l   <= 1'b0;
    end else if (clr) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (first_bit) begin
        dir_l <= dir;
      end
      if (data_bit) begin
        sh <= sh_shift;
      end
      bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
    end
  end

  // Output holding register and handshake; a load and a consume on the same
  // edge leave out_valid high so back-to-back words see no bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out       <= '0;
      out_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else if (load) begin
      out       <= cand;
      out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
      // Even parity over data plus parity bit; nonzero means an error.
      par_err   <= ^{sh, d};
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun flag, cleared only by reset or the resync input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=16): a table of whole-word
// transactions followed by hand-written multi-cycle sequences.
module tb_sipo_deserializer;

  localparam int unsigned WIDTH = 16;
`ifdef SIPO_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
`else
  localparam int unsigned FL = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             d;
  logic             en;
  logic             dir;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
`ifdef SIPO_PARITY_EN
  logic             par_err;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rx  = 0;
  bit          scb_on = 1'b0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] word;
    logic        dr;
    logic        dr2;
    logic        rdy;
    logic        par;
    logic [15:0] exp_out;
    logic        exp_valid;
    logic        exp_ovr;
  } vec_t;

  vec_t vt[7];

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .d         (d),
    .en        (en),
    .dir       (dir),
    .clr       (clr),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bit_cnt   (bit_cnt),
`ifdef SIPO_PARITY_EN
    .par_err   (par_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One clock: drive at negedge, observe 1 time unit after the rising edge.
  task automatic step(input logic bd, input logic ben, input logic bdir,
                      input logic bclr, input logic brdy);
    @(negedge clk);
    d = bd; en = ben; dir = bdir; clr = bclr; out_ready = brdy;
    if (scb_on && out_valid && brdy) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scb_extra: got %0h expected no word", out);
      end else begin
        chk("scb_word", 64'(out), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Full frame with en held high; dir switches to dr2 after the sixth bit.
  task automatic send_word(input logic [15:0] w, input logic dr, input logic dr2,
                           input logic rdy, input logic par);
    for (int i = 0; i < 16; i++) begin
      logic b;
      b = dr ? w[i] : w[15-i];
      step(b, 1'b1, (i < 6) ? dr : dr2, 1'b0, rdy);
      chk("bit_cnt", 64'(bit_cnt), 64'((i + 1) % FL));
    end
`ifdef SIPO_PARITY_EN
    step(par, 1'b1, dr2, 1'b0, rdy);
    chk("bit_cnt_par", 64'(bit_cnt), 64'(0));
`else
    if (par === 1'bx) $display("unexpected X parity");
`endif
  endtask

  // MSB-first frame with random en gaps and random ready, ready high on the
  // completing edge.
  task automatic send_gappy(input logic [15:0] w);
    exp_q.push_back(w);
    for (int i = 0; i < int'(FL); i++) begin
      int unsigned gaps;
      logic b;
      gaps = $urandom_range(3, 0);
      for (int g = 0; g < int'(gaps); g++) begin
        step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'($urandom));
      end
      b = (i < 16) ? w[15-i] : ^w;
      step(b, 1'b1, 1'b0, 1'b0, (i == int'(FL) - 1) ? 1'b1 : 1'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b0};
    vt[1] = '{16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0};
    vt[2] = '{16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b0};
    vt[3] = '{16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b1, 1'b1};
    vt[4] = '{16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b1};
    vt[5] = '{16'h8003, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8003, 1'b1, 1'b1};
    vt[6] = '{16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b1};

    rstn = 1'b0; d = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_bit_cnt", 64'(bit_cnt), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Word-level table
    for (int i = 0; i < 7; i++) begin
      send_word(vt[i].word, vt[i].dr, vt[i].dr2, vt[i].rdy, vt[i].par);
      chk($sformatf("v%0d_out", i), 64'(out), 64'(vt[i].exp_out));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      chk($sformatf("v%0d_overrun", i), 64'(overrun), 64'(vt[i].exp_ovr));
`ifdef SIPO_PARITY_EN
      chk($sformatf("v%0d_par_err", i), 64'(par_err), 64'(0));
`endif
    end

    // Consume with no completion: valid drops, out and overrun hold
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cons_valid", 64'(out_valid), 64'(0));
    chk("cons_out", 64'(out), 64'(16'h0F0F));
    chk("cons_overrun", 64'(overrun), 64'(1));

    // Partial word then clr with en=1, d=1
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("part_bit_cnt", 64'(bit_cnt), 64'(5));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_bit_cnt", 64'(bit_cnt), 64'(0));
    chk("clr_overrun", 64'(overrun), 64'(0));
    chk("clr_out", 64'(out), 64'(16'h0F0F));
    chk("clr_valid", 64'(out_valid), 64'(0));
    send_word(16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("beef_out", 64'(out), 64'(16'hBEEF));
    chk("beef_valid", 64'(out_valid), 64'(1));

    // Hold with en=0, then asynchronous reset mid-word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_bit_cnt", 64'(bit_cnt), 64'(3));
    chk("hold_valid", 64'(out_valid), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out", 64'(out), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_bit_cnt", 64'(bit_cnt), 64'(0));
    chk("arst_overrun", 64'(overrun), 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Irregular strobes and ready, 16 back-to-back words
    scb_on = 1'b1;
    for (int k = 1; k <= 16; k++) send_gappy(16'(k));
    for (int k = 0; k < 8; k++) begin
      if (out_valid) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    scb_on = 1'b0;
    chk("scb_count", 64'(n_rx), 64'(16));
    chk("scb_left", 64'(exp_q.size()), 64'(0));
    chk("scb_overrun", 64'(overrun), 64'(0));
    chk("scb_valid", 64'(out_valid), 64'(0));

`ifdef SIPO_PARITY_EN
    send_word(16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par3_out", 64'(out), 64'(16'h0003));
    chk("par3_err", 64'(par_err), 64'(0));
    send_word(16'h0007, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par7_out", 64'(out), 64'(16'h0007));
    chk("par7_err", 64'(par_err), 64'(1));
    send_word(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pardrop_out", 64'(out), 64'(16'h0007));
    chk("pardrop_err", 64'(par_err), 64'(1));
    chk("pardrop_overrun", 64'(overrun), 64'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
